// File: rtl/m_ext_issue_ctrl.sv
// rtl/m_ext_issue_ctrl.sv - RV32M issue/return controller for a combinational M unit
// Optional feature macro: M_EXT_RESULT_CACHE_EN (single-entry result cache)
module m_ext_issue_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [31:0] o_m_a,
  output logic [31:0] o_m_b,
  output logic        o_m_sign,
  output logic        o_m_mix,
  output logic        o_m_div,
  input  logic [31:0] i_m_uh,
  input  logic [31:0] i_m_lh
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_rsp_data;
  logic [31:0] r_m_a;
  logic [31:0] r_m_b;
  logic        r_m_sign;
  logic        r_m_mix;
  logic        r_m_div;
  logic        r_sel_lh;

  logic        w_accept;
  logic        w_sign;
  logic        w_mix;
  logic        w_div;
  logic        w_sel_lh;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_data;
  logic        w_hit;
  logic [31:0] w_hit_data;
  logic        w_cnt_zero;
  logic [31:0] w_unit_data;

  assign w_accept    = i_req_valid & o_req_ready;
  assign w_cnt_zero  = (r_cnt == 4'd0);
  assign w_unit_data = r_sel_lh ? i_m_lh : i_m_uh;

  // funct3 decode into unit controls and which half carries the result
  always_comb begin
    w_sign   = 1'b0;
    w_mix    = 1'b0;
    w_div    = 1'b0;
    w_sel_lh = 1'b0;
    case (i_req_funct3)
      3'b000: begin w_sign = 1'b1; w_sel_lh = 1'b1; end
      3'b001: begin w_sign = 1'b1; end
      3'b010: begin w_sign = 1'b1; w_mix = 1'b1; end
      3'b011: begin end
      3'b100: begin w_sign = 1'b1; w_div = 1'b1; end
      3'b101: begin w_div = 1'b1; end
      3'b110: begin w_sign = 1'b1; w_div = 1'b1; w_sel_lh = 1'b1; end
      default: begin w_div = 1'b1; w_sel_lh = 1'b1; end
    endcase
  end

  // divide-by-zero and signed-overflow results are known without the unit
  always_comb begin
    w_div_zero = w_div & (i_req_b == 32'd0);
    w_ovf      = w_div & w_sign & (i_req_a == 32'h8000_0000) & (i_req_b == 32'hFFFF_FFFF);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_data = w_sel_lh ? i_req_a : 32'hFFFF_FFFF;
    end else begin
      w_special_data = w_sel_lh ? 32'd0 : 32'h8000_0000;
    end
  end

`ifdef M_EXT_RESULT_CACHE_EN
  logic        r_c_valid;
  logic [31:0] r_c_a;
  logic [31:0] r_c_b;
  logic        r_c_sign;
  logic        r_c_mix;
  logic        r_c_div;
  logic [31:0] r_c_uh;
  logic [31:0] r_c_lh;

  // hit when operands and controls match the last unit result
  always_comb begin
    w_hit      = r_c_valid & (r_c_a == i_req_a) & (r_c_b == i_req_b) &
                 (r_c_sign == w_sign) & (r_c_mix == w_mix) & (r_c_div == w_div);
    w_hit_data = w_sel_lh ? r_c_lh : r_c_uh;
  end

  // fill the cache only from a genuine unit capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c_valid <= 1'b0;
      r_c_a     <= 32'd0;
      r_c_b     <= 32'd0;
      r_c_sign  <= 1'b0;
      r_c_mix   <= 1'b0;
      r_c_div   <= 1'b0;
      r_c_uh    <= 32'd0;
      r_c_lh    <= 32'd0;
    end else if (r_state == S_WAIT && w_cnt_zero) begin
      r_c_valid <= 1'b1;
      r_c_a     <= r_m_a;
      r_c_b     <= r_m_b;
      r_c_sign  <= r_m_sign;
      r_c_mix   <= r_m_mix;
      r_c_div   <= r_m_div;
      r_c_uh    <= i_m_uh;
      r_c_lh    <= i_m_lh;
    end
  end
`else
  // no cache: every non-special op goes to the unit
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = 32'd0;
  end
`endif

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_special | w_hit) ? S_DONE : S_WAIT;
      S_WAIT: if (w_cnt_zero) w_next = S_DONE;
      S_DONE: if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    o_req_ready = (r_state == S_IDLE);
    o_rsp_valid = (r_state == S_DONE);
  end

  // operand launch, latency count and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= 4'd0;
      r_rsp_data <= 32'd0;
      r_m_a      <= 32'd0;
      r_m_b      <= 32'd0;
      r_m_sign   <= 1'b0;
      r_m_mix    <= 1'b0;
      r_m_div    <= 1'b0;
      r_sel_lh   <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_sel_lh <= w_sel_lh;
      if (w_hit && !w_special) begin
        r_rsp_data <= w_hit_data;
      end else begin
        r_m_a    <= i_req_a;
        r_m_b    <= i_req_b;
        r_m_sign <= w_sign;
        r_m_mix  <= w_mix;
        r_m_div  <= w_div;
        if (w_special) begin
          r_rsp_data <= w_special_data;
        end else begin
          r_cnt <= CNT_INIT;
        end
      end
    end else if (r_state == S_WAIT) begin
      if (w_cnt_zero) begin
        r_rsp_data <= w_unit_data;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign o_rsp_data = r_rsp_data;
  assign o_m_a      = r_m_a;
  assign o_m_b      = r_m_b;
  assign o_m_sign   = r_m_sign;
  assign o_m_mix    = r_m_mix;
  assign o_m_div    = r_m_div;

endmodule

// File: tb/tb_m_ext_issue_ctrl.sv
// tb/tb_m_ext_issue_ctrl.sv - scoreboard bench for m_ext_issue_ctrl
module tb_m_ext_issue_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sign;
  logic        m_mix;
  logic        m_div;
  logic [31:0] m_uh;
  logic [31:0] m_lh;
  logic        force_x;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t q_exp[$];

  bit          bc_valid;
  logic [31:0] bc_a;
  logic [31:0] bc_b;
  logic [2:0]  bc_ctl;

  always #5 clk = ~clk;

  m_ext_issue_ctrl #(.LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_funct3(req_funct3),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_m_a(m_a), .o_m_b(m_b), .o_m_sign(m_sign), .o_m_mix(m_mix), .o_m_div(m_div),
    .i_m_uh(m_uh), .i_m_lh(m_lh)
  );

  // behavioural combinational M unit driven by the DUT controls
  logic [63:0] ux, uy, up;
  always_comb begin
    ux = m_sign ? {{32{m_a[31]}}, m_a} : {32'd0, m_a};
    uy = (m_sign && !m_mix) ? {{32{m_b[31]}}, m_b} : {32'd0, m_b};
    up = ux * uy;
    m_uh = up[63:32];
    m_lh = up[31:0];
    if (m_div) begin
      if (m_b == 32'd0 || (m_sign && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF)) begin
        m_uh = 'x;
        m_lh = 'x;
      end else if (m_sign) begin
        m_uh = $signed(m_a) / $signed(m_b);
        m_lh = $signed(m_a) % $signed(m_b);
      end else begin
        m_uh = m_a / m_b;
        m_lh = m_a % m_b;
      end
    end
    if (force_x) begin
      m_uh = 'x;
      m_lh = 'x;
    end
  end

  function automatic logic [2:0] ctl_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b001: return 3'b100;
      3'b010:         return 3'b110;
      3'b011:         return 3'b000;
      3'b100, 3'b110: return 3'b101;
      default:        return 3'b001;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    ia = a; ib = b;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic push_expected(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit special;
    special = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    e.data = ref_result(f, a, b);
    if (special) begin
      e.lat = 1;
    end else begin
      e.lat = LAT + 1;
`ifdef M_EXT_RESULT_CACHE_EN
      if (bc_valid && bc_a == a && bc_b == b && bc_ctl == ctl_of(f)) begin
        e.lat = 1;
      end else begin
        bc_valid = 1'b1; bc_a = a; bc_b = b; bc_ctl = ctl_of(f);
      end
`endif
    end
    q_exp.push_back(e);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] data, output int lat, output bit stable);
    int n;
    push_expected(f, a, b);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_funct3 = f; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_funct3 = 3'($urandom);
    lat = 0; stable = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    data = rsp_data;
    if (rsp_valid) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_data !== data || !rsp_valid || req_ready) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] data, input int lat);
    exp_t e;
    e = q_exp.pop_front();
    n_total++;
    if (data !== e.data) $display("FAIL %s data: got %h expected %h", name, data, e.data);
    else n_pass++;
    n_total++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    else n_pass++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bc_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b expected 1", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 32'd0) $display("FAIL reset rsp_data: got %h expected 0", rsp_data); else n_pass++;
    n_total++; if ({m_a, m_b, m_sign, m_mix, m_div} !== 67'd0)
      $display("FAIL reset m_outputs: got %h %h %b%b%b expected zeros", m_a, m_b, m_sign, m_mix, m_div);
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] d; int l; bit s;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, d, l, s);
    check_op("mul", d, l);
    n_total++; if ({m_sign, m_mix, m_div} !== 3'b100)
      $display("FAIL mul ctrl: got %b%b%b expected 100", m_sign, m_mix, m_div);
    else n_pass++;
    n_total++; if (m_a !== 32'd7 || m_b !== 32'hFFFF_FFFD)
      $display("FAIL mul operands: got %h %h expected 7 fffffffd", m_a, m_b);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    logic [31:0] d; int l; bit s;
    force_x = 1'b1;
    do_op(3'b101, 32'd100, 32'd0, 0, d, l, s);
    check_op("divu_by_zero", d, l);
    do_op(3'b111, 32'd100, 32'd0, 0, d, l, s);
    check_op("remu_by_zero", d, l);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd0, 0, d, l, s);
    check_op("rem_by_zero", d, l);
    force_x = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d; int l; bit s;
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, d, l, s);
    check_op("div_overflow", d, l);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, d, l, s);
    check_op("rem_overflow", d, l);
    n_total++; if ({m_sign, m_mix, m_div} !== 3'b101)
      $display("FAIL overflow ctrl: got %b%b%b expected 101", m_sign, m_mix, m_div);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d; int l; bit s;
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5, d, l, s);
    check_op("mulhsu_backpressure", d, l);
    n_total++; if (s !== 1'b1) $display("FAIL backpressure hold: got stable=%b expected 1", s); else n_pass++;
    n_total++; if ({m_sign, m_mix, m_div} !== 3'b110)
      $display("FAIL mulhsu ctrl: got %b%b%b expected 110", m_sign, m_mix, m_div);
    else n_pass++;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL post_handshake: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b011; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b0) $display("FAIL wait req_ready: got %b expected 0", req_ready); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bc_valid = 1'b0;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'd0)
      $display("FAIL reset_in_wait: got valid=%b ready=%b data=%h expected 0 1 0", rsp_valid, req_ready, rsp_data);
    else n_pass++;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    n_total++; if (seen !== 0) $display("FAIL dropped_op_response: got %0d valid cycles expected 0", seen); else n_pass++;
  endtask

  task automatic test_cache();
    logic [31:0] d; int l; bit s;
    do_op(3'b001, 32'h0001_0000, 32'h0001_0000, 0, d, l, s);
    check_op("cache_mulh", d, l);
    do_op(3'b000, 32'h0001_0000, 32'h0001_0000, 0, d, l, s);
    check_op("cache_mul", d, l);
    n_total++; if (m_a !== 32'h0001_0000 || m_b !== 32'h0001_0000 || {m_sign, m_mix, m_div} !== 3'b100)
      $display("FAIL cache m_outputs: got %h %h %b%b%b expected 10000 10000 100", m_a, m_b, m_sign, m_mix, m_div);
    else n_pass++;
    do_op(3'b100, 32'd100, 32'd7, 0, d, l, s);
    check_op("cache_div", d, l);
    do_op(3'b110, 32'd100, 32'd7, 0, d, l, s);
    check_op("cache_rem", d, l);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a, b; int l; bit s;
    logic [2:0] f;
    a = 32'd0; b = 32'd1;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      if (i % 3 != 2) begin
        a = $urandom;
        b = (i % 5 == 0) ? 32'd0 : $urandom;
        if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      end
      do_op(f, a, b, i % 3, d, l, s);
      check_op($sformatf("b2b_%0d_f%0d", i, f), d, l);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0; force_x = 1'b0; bc_valid = 1'b0;
    bc_a = 32'd0; bc_b = 32'd0; bc_ctl = 3'd0;
    test_reset();
    test_mul();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_in_wait();
    test_cache();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
